pipelined_adder: RTL and testbench
==================================

Name: pipelined_adder

Overview:
- Parametrised, pipelined successor to the datapath's 32-bit combinational adder.
- Computes A+B or A−B over WIDTH bits, splitting the carry chain into STAGES registered chunks so the adder meets timing at higher clock rates.
- Uses a valid/ready handshake on input and output, and reports carry, signed overflow and zero.
- Used by the PC/branch-target path and the ALU when they are pipelined.

Parameters:
- WIDTH, 32, operand/result width in bits. Must be divisible by STAGES.
- STAGES, 2, pipeline depth (1..4). Each stage resolves WIDTH/STAGES bits of the carry chain.

Ports:
- Clk  input  1  clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- InValid  input  1  operand beat present.
- InReady  output  1  block accepts the beat this cycle.
- InputA  input  WIDTH  operand A.
- InputB  input  WIDTH  operand B.
- Sub  input  1  0: A+B; 1: A−B (A + ~B + 1).
- OutValid  output  1  result beat present.
- OutReady  input  1  consumer accepts the result.
- AddResult  output  WIDTH  sum/difference, modulo 2^WIDTH.
- CarryOut  output  1  carry out of the MSB. For Sub=1, 1 means no borrow.
- Overflow  output  1  two's-complement signed overflow.
- Zero  output  1  AddResult == 0.

Behaviour:
- Reset (sampled at the edge):
  - All stage valid bits clear; OutValid=0.
  - AddResult, CarryOut, Overflow, Zero = 0.
  - InReady=0 while Reset is high.
  - In-flight beats are discarded, never emitted.
  - First accept is possible in the cycle after Reset deasserts.
- Advance enable: adv = !OutValid || OutReady. InReady = adv && !Reset.
- Accept: a beat is accepted when InValid && InReady.
- Pipeline motion:
  - When adv=1, every stage shifts by one.
  - Stage 0 loads the accepted beat, or a bubble (valid=0) if none is accepted.
  - When adv=0, all stages hold.
  - Bubbles are not squeezed out.
- Latency and throughput:
  - Exactly STAGES cycles from accept to OutValid with no back-pressure.
  - Throughput: 1 beat per cycle.
- Stage k (chunk width C=WIDTH/STAGES):
  - Adds bits [k*C +: C] of A and B' (B' = Sub ? ~B : B) plus the registered carry from stage k−1.
  - Stage 0 carry-in = Sub.
  - Unconsumed upper operand chunks are carried forward registered (skewed).
  - Completed lower result chunks are carried forward registered.
- Final-stage flags:
  - CarryOut = carry out of bit WIDTH−1.
  - Overflow = (A[MSB] == B'[MSB]) && (AddResult[MSB] != A[MSB]).
  - Zero from the full result.
- Output registers:
  - Outputs are registered and change only when adv=1.
  - While OutValid=1 and OutReady=0, AddResult and the flags hold stable.
- Simultaneous events:
  - Output handshake and input accept in the same cycle are both honoured.
  - Reset wins over any handshake.
- Ordering: results emerge in acceptance order; no loss, no duplication.
- STAGES=1: a single registered full-width adder with latency 1.
- Wrap-around: results are modulo 2^WIDTH; CarryOut/Overflow report the wrap.

Test Plan (WIDTH=32, STAGES=2 unless noted):
1. Basic add, OutReady=1: A=0x00000004, B=0x00400000, Sub=0 -> 2 cycles after accept: OutValid=1, AddResult=0x00400004, CarryOut=0, Overflow=0, Zero=0.
2. Cross-chunk carry and wrap: A=0xFFFFFFFF, B=0x00000001 -> AddResult=0x00000000, CarryOut=1, Zero=1, Overflow=0. Also A=0x0000FFFF, B=1 -> 0x00010000.
3. Signed overflow: A=0x7FFFFFFF, B=1 -> AddResult=0x80000000, Overflow=1, CarryOut=0. Also A=0x80000000, B=0x80000000 -> 0x00000000, Overflow=1, CarryOut=1.
4. Subtract: A=5, B=7, Sub=1 -> 0xFFFFFFFE, CarryOut=0, Overflow=0. A=7, B=5 -> 0x00000002, CarryOut=1. A=B=0x12345678 -> 0, Zero=1.
5. Back-pressure: stream 4 beats (1+1, 2+2, 3+3, 4+4) back-to-back; hold OutReady=0 for 3 cycles after the first OutValid -> InReady=0 and AddResult held at 2 throughout the stall; on release, outputs are exactly 2, 4, 6, 8 in order with no gaps beyond the stall and no duplicates.
6. Reset mid-flight: accept 2 beats, assert Reset for 1 cycle before the first emerges -> OutValid=0 and all outputs 0 the cycle after; nothing emitted for those beats; a new beat accepted after reset emerges with latency 2. Repeat the scenarios with STAGES=1 (latency 1) and STAGES=4 (latency 4).

Source files
------------

// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit adder/subtractor: the carry chain is cut into STAGES registered
// chunks with a valid/ready handshake on both sides; carry, signed overflow and zero flags.
module pipelined_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] InputA,
    input  logic [WIDTH-1:0] InputB,
    input  logic             Sub,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] AddResult,
    output logic             CarryOut,
    output logic             Overflow,
    output logic             Zero
);

    localparam int CHUNK = WIDTH / STAGES;

    logic              adv;
    logic              accept;
    logic [STAGES-1:0] valid_q, valid_d;
    logic [STAGES-1:0] carry_q, carry_d;
    logic [WIDTH-1:0]  opa_q [STAGES];
    logic [WIDTH-1:0]  opa_d [STAGES];
    logic [WIDTH-1:0]  opb_q [STAGES];
    logic [WIDTH-1:0]  opb_d [STAGES];
    logic [WIDTH-1:0]  sum_q [STAGES];
    logic [WIDTH-1:0]  sum_d [STAGES];
    logic              ovf_q, ovf_d;
    logic              zero_q, zero_d;

    assign adv     = !valid_q[STAGES-1] || OutReady;
    assign InReady = adv && !Reset;
    assign accept  = InValid && InReady;

    // Each stage resolves one chunk; operands travel whole so later stages see their chunk.
    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            logic [WIDTH-1:0] a_src;
            logic [WIDTH-1:0] b_src;
            logic [WIDTH-1:0] sum_src;
            logic [WIDTH-1:0] sum_new;
            logic             c_src;
            logic             v_src;
            logic [CHUNK:0]   chunk_sum;

            if (gi == 0) begin : g_first
                assign a_src   = InputA;
                assign b_src   = Sub ? ~InputB : InputB;
                assign sum_src = '0;
                assign c_src   = Sub;
                assign v_src   = accept;
            end else begin : g_next
                assign a_src   = opa_q[gi-1];
                assign b_src   = opb_q[gi-1];
                assign sum_src = sum_q[gi-1];
                assign c_src   = carry_q[gi-1];
                assign v_src   = valid_q[gi-1];
            end

            assign chunk_sum = {1'b0, a_src[gi*CHUNK +: CHUNK]}
                             + {1'b0, b_src[gi*CHUNK +: CHUNK]}
                             + {{CHUNK{1'b0}}, c_src};

            always_comb begin
                sum_new = sum_src;
                sum_new[gi*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
            end

            assign opa_d[gi]   = a_src;
            assign opb_d[gi]   = b_src;
            assign sum_d[gi]   = sum_new;
            assign carry_d[gi] = chunk_sum[CHUNK];
            assign valid_d[gi] = v_src;

            if (gi == STAGES - 1) begin : g_flags
                assign ovf_d  = (a_src[WIDTH-1] == b_src[WIDTH-1]) &&
                                (sum_new[WIDTH-1] != a_src[WIDTH-1]);
                assign zero_d = (sum_new == '0);
            end
        end
    endgenerate

    // Bubbles advance the valid bits but leave data untouched, so outputs hold after a drain.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            valid_q <= '0;
            carry_q <= '0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                opa_q[k] <= '0;
                opb_q[k] <= '0;
                sum_q[k] <= '0;
            end
        end else if (adv) begin
            valid_q <= valid_d;
            for (int k = 0; k < STAGES; k++) begin
                if (valid_d[k]) begin
                    opa_q[k]   <= opa_d[k];
                    opb_q[k]   <= opb_d[k];
                    sum_q[k]   <= sum_d[k];
                    carry_q[k] <= carry_d[k];
                end
            end
            if (valid_d[STAGES-1]) begin
                ovf_q  <= ovf_d;
                zero_q <= zero_d;
            end
        end
    end

    assign OutValid  = valid_q[STAGES-1];
    assign AddResult = sum_q[STAGES-1];
    assign CarryOut  = carry_q[STAGES-1];
    assign Overflow  = ovf_q;
    assign Zero      = zero_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: instances with STAGES=2, 1 and 4 exercised one at a time
// with a vector table, reset/back-pressure sequences and a randomized scoreboard run.
module tb_pipelined_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [2:0]  in_valid, in_ready, out_valid, out_ready, sub, carry, ovf, zero;
    logic [31:0] in_a [3];
    logic [31:0] in_b [3];
    logic [31:0] res  [3];

    pipelined_adder #(.WIDTH(32), .STAGES(2)) u_s2 (
        .Clk(clk), .Reset(rst), .InValid(in_valid[0]), .InReady(in_ready[0]),
        .InputA(in_a[0]), .InputB(in_b[0]), .Sub(sub[0]), .OutValid(out_valid[0]),
        .OutReady(out_ready[0]), .AddResult(res[0]), .CarryOut(carry[0]),
        .Overflow(ovf[0]), .Zero(zero[0]));
    pipelined_adder #(.WIDTH(32), .STAGES(1)) u_s1 (
        .Clk(clk), .Reset(rst), .InValid(in_valid[1]), .InReady(in_ready[1]),
        .InputA(in_a[1]), .InputB(in_b[1]), .Sub(sub[1]), .OutValid(out_valid[1]),
        .OutReady(out_ready[1]), .AddResult(res[1]), .CarryOut(carry[1]),
        .Overflow(ovf[1]), .Zero(zero[1]));
    pipelined_adder #(.WIDTH(32), .STAGES(4)) u_s4 (
        .Clk(clk), .Reset(rst), .InValid(in_valid[2]), .InReady(in_ready[2]),
        .InputA(in_a[2]), .InputB(in_b[2]), .Sub(sub[2]), .OutValid(out_valid[2]),
        .OutReady(out_ready[2]), .AddResult(res[2]), .CarryOut(carry[2]),
        .Overflow(ovf[2]), .Zero(zero[2]));

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [31:0] res;
        logic        c;
        logic        v;
        logic        z;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic        c;
        logic        v;
        logic        z;
    } exp_t;

    vec_t        vecs [10];
    exp_t        sb_q [$];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          sel = 0;
    int          cyc = 0;
    bit          last_acc, last_out, prev_stall;
    logic [31:0] last_res;
    logic [35:0] prev_snap;

    function automatic int lat_of(input int s);
        return (s == 0) ? 2 : (s == 1) ? 1 : 4;
    endfunction

    // Reference: plain unsigned/signed arithmetic, no carry-chain modelling.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
        exp_t   e;
        longint r;
        if (s) begin
            e.res = a - b;
            e.c   = (a >= b);
            r     = longint'($signed(a)) - longint'($signed(b));
        end else begin
            e.res = a + b;
            e.c   = (({32'h0, a} + {32'h0, b}) > 64'h0000_0000_FFFF_FFFF);
            r     = longint'($signed(a)) + longint'($signed(b));
        end
        e.v = (r > 64'sd2147483647) || (r < -64'sd2147483648);
        e.z = (e.res == 32'h0);
        return e;
    endfunction

    function automatic logic [31:0] rand_op();
        case ($urandom_range(0, 4))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (dut %0d, cycle %0d)", name, act, exp, sel, cyc);
        end
    endtask

    // Called at the falling edge: records handshakes that the next rising edge will take.
    task automatic sample();
        exp_t e;
        last_acc = 1'b0;
        last_out = 1'b0;
        if (!rst) begin
            if (prev_stall)
                check("stall_hold", {out_valid[sel], res[sel], carry[sel], ovf[sel], zero[sel]}, prev_snap);
            if (in_valid[sel] && in_ready[sel]) begin
                last_acc = 1'b1;
                sb_q.push_back(model(in_a[sel], in_b[sel], sub[sel]));
            end
            if (out_valid[sel] && out_ready[sel]) begin
                last_out = 1'b1;
                last_res = res[sel];
                check("sb_nonempty", sb_q.size() != 0, 1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    check("sb_res", res[sel], e.res);
                    check("sb_carry", carry[sel], e.c);
                    check("sb_ovf", ovf[sel], e.v);
                    check("sb_zero", zero[sel], e.z);
                end
                $display("dut%0d cycle %0d: out res=0x%08h c=%0b v=%0b z=%0b",
                         sel, cyc, res[sel], carry[sel], ovf[sel], zero[sel]);
            end
        end
        prev_stall = !rst && out_valid[sel] && !out_ready[sel];
        prev_snap  = {out_valid[sel], res[sel], carry[sel], ovf[sel], zero[sel]};
        cyc++;
    endtask

    task automatic tick();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_one(input vec_t v);
        int lat;
        in_a[sel]      = v.a;
        in_b[sel]      = v.b;
        sub[sel]       = v.sub;
        in_valid[sel]  = 1'b1;
        out_ready[sel] = 1'b1;
        tick();
        check("accept", last_acc, 1);
        in_valid[sel] = 1'b0;
        lat = 1;
        while (!out_valid[sel] && lat <= 12) begin
            tick();
            lat++;
        end
        check("latency", lat, lat_of(sel));
        check("vec_res", res[sel], v.res);
        check("vec_carry", carry[sel], v.c);
        check("vec_ovf", ovf[sel], v.v);
        check("vec_zero", zero[sel], v.z);
    endtask

    task automatic reset_test();
        int n_acc;
        int n_out;
        vec_t v;
        n_acc = 0;
        n_out = 0;
        in_a[sel]      = 32'hFFFF_FFFF;
        in_b[sel]      = 32'h0000_0002;
        sub[sel]       = 1'b0;
        out_ready[sel] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid[sel] = 1'b1;
            tick();
            if (last_acc) n_acc++;
        end
        in_valid[sel] = 1'b0;
        check("rst_pre_accepts", n_acc >= 1, 1);
        rst = 1'b1;
        out_ready[sel] = 1'b1;
        #1;
        check("rst_in_ready", in_ready[sel], 0);
        tick();
        sb_q.delete();
        rst = 1'b0;
        #1;
        check("rst_out_valid", out_valid[sel], 0);
        check("rst_res", res[sel], 0);
        check("rst_flags", {carry[sel], ovf[sel], zero[sel]}, 0);
        check("rst_ready_after", in_ready[sel], 1);
        for (int i = 0; i < lat_of(sel) + 2; i++) begin
            tick();
            if (last_out) n_out++;
        end
        check("rst_no_emit", n_out, 0);
        v = vecs[6];
        drive_one(v);
        tick();
    endtask

    task automatic random_test(input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            in_a[sel]      = rand_op();
            in_b[sel]      = rand_op();
            sub[sel]       = 1'($urandom_range(0, 1));
            in_valid[sel]  = ($urandom_range(0, 3) != 0);
            out_ready[sel] = ($urandom_range(0, 3) != 0);
            tick();
        end
        in_valid[sel]  = 1'b0;
        out_ready[sel] = 1'b1;
        for (int i = 0; i < 12 && sb_q.size() != 0; i++) tick();
        check("drain_empty", sb_q.size(), 0);
        tick();
    endtask

    task automatic backpressure_test();
        int fed;
        int got;
        int stall;
        int prev_out_cyc;
        bit seen_first;
        fed = 0;
        got = 0;
        stall = 0;
        prev_out_cyc = -1;
        seen_first = 1'b0;
        sub[sel] = 1'b0;
        for (int c = 0; c < 30 && got < 4; c++) begin
            in_valid[sel] = (fed < 4);
            in_a[sel]     = 32'(fed + 1);
            in_b[sel]     = 32'(fed + 1);
            if (!seen_first && out_valid[sel]) begin
                seen_first = 1'b1;
                stall = 3;
            end
            out_ready[sel] = (stall == 0);
            if (stall > 0) begin
                #1;
                check("bp_in_ready", in_ready[sel], 0);
                check("bp_hold_res", res[sel], 2);
                check("bp_out_valid", out_valid[sel], 1);
                stall--;
            end
            tick();
            if (last_acc) fed++;
            if (last_out) begin
                got++;
                check("bp_order", last_res, 2 * got);
                if (prev_out_cyc >= 0) check("bp_no_gap", cyc - prev_out_cyc, 1);
                prev_out_cyc = cyc;
            end
        end
        check("bp_count", got, 4);
        in_valid[sel] = 1'b0;
        tick();
    endtask

    initial begin
        vecs[0] = '{32'h0000_0004, 32'h0040_0000, 1'b0, 32'h0040_0004, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1};
        vecs[5] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{32'h0000_0007, 32'h0000_0005, 1'b1, 32'h0000_0002, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{32'h1234_5678, 32'h1234_5678, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        vecs[8] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
        vecs[9] = '{32'h0000_0000, 32'h8000_0000, 1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b0};

        rst        = 1'b1;
        in_valid   = '0;
        out_ready  = '1;
        sub        = '0;
        prev_stall = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_a[i] = '0;
            in_b[i] = '0;
        end
        repeat (2) tick();
        for (int i = 0; i < 3; i++) begin
            sel = i;
            check("reset_out_valid", out_valid[i], 0);
            check("reset_in_ready", in_ready[i], 0);
            check("reset_outputs", {res[i], carry[i], ovf[i], zero[i]}, 0);
        end
        rst = 1'b0;
        #1;

        for (int s = 0; s < 3; s++) begin
            sel = s;
            for (int k = 0; k < 10; k++) drive_one(vecs[k]);
            tick();
            reset_test();
            random_test(300);
        end
        sel = 0;
        backpressure_test();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
